bist_scheduler: RTL and testbench

Session-level scheduler for the built-in self-test subsystem. It shares one BIST pattern controller and one MISR/signature comparator among NUM_CUT circuits under test, running them one at a time. For each CUT it selects the target, clears the MISR, launches the controller, waits for completion with a timeout, and records the signature result. Its per-CUT fail vector and overall pass/done flags are the values the test access logic reads out.

---
 rtl/bist_scheduler_if.sv | 30 +++
 rtl/bist_scheduler.sv | 136 +++++++++++++
 tb/tb_bist_scheduler.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bist_scheduler_if.sv
// BIST controller / MISR side of the session scheduler.
// master drives target select and pulses; slave returns status.
interface bist_scheduler_if #(
  parameter int SEL_W = 2
);
  logic             ctrl_start;
  logic             misr_clr;
  logic [SEL_W-1:0] cut_sel;
  logic             ctrl_running;
  logic             ctrl_bist_end;
  logic             sig_match;

  modport master (
    output ctrl_start,
    output misr_clr,
    output cut_sel,
    input  ctrl_running,
    input  ctrl_bist_end,
    input  sig_match
  );

  modport slave (
    input  ctrl_start,
    input  misr_clr,
    input  cut_sel,
    output ctrl_running,
    output ctrl_bist_end,
    output sig_match
  );
endinterface

// File: rtl/bist_scheduler.sv
// BIST session scheduler: runs each CUT through one shared
// pattern controller and MISR, collecting per-CUT results.
module bist_scheduler #(
  parameter int NUM_CUT = 4,
  parameter int SEL_W   = 2,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  bist_scheduler_if.master   bus,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_CUT-1:0] fail_vec,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [SEL_W-1:0] LAST   = SEL_W'(NUM_CUT - 1);
  localparam logic [TO_W-1:0]  TO_LIM = TO_W'(TIMEOUT);

  state_t            state;
  logic              prev_start;
  logic              seen_run;
  logic [TO_W-1:0]   timer;
  logic [SEL_W-1:0]  sel_q;
  logic              ctrl_start_q;
  logic              misr_clr_q;

  logic start_edge;
  logic complete;
  logic expired;

  assign start_edge = start & ~prev_start;
  // end flag only counts once this run was seen running
  assign complete   = seen_run & bus.ctrl_bist_end;
  assign expired    = (timer == TO_LIM);

  assign bus.ctrl_start = ctrl_start_q;
  assign bus.misr_clr   = misr_clr_q;
  assign bus.cut_sel    = sel_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      prev_start   <= 1'b0;
      seen_run     <= 1'b0;
      timer        <= '0;
      sel_q        <= '0;
      ctrl_start_q <= 1'b0;
      misr_clr_q   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_vec     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      prev_start   <= start;
      ctrl_start_q <= 1'b0;
      misr_clr_q   <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
        pass  <= 1'b0;
        sel_q <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start_edge) begin
              state       <= S_CLEAR;
              sel_q       <= '0;
              fail_vec    <= '0;
              timeout_err <= 1'b0;
              done        <= 1'b0;
              pass        <= 1'b0;
              busy        <= 1'b1;
              misr_clr_q  <= 1'b1;
            end
          end
          S_CLEAR: begin
            state        <= S_LAUNCH;
            ctrl_start_q <= 1'b1;
          end
          S_LAUNCH: begin
            state    <= S_WAIT;
            timer    <= '0;
            seen_run <= 1'b0;
          end
          S_WAIT: begin
            if (bus.ctrl_running)
              seen_run <= 1'b1;
            if (complete) begin
              fail_vec[sel_q] <= ~bus.sig_match;
              state           <= S_CHECK;
            end else if (expired) begin
              fail_vec[sel_q] <= 1'b1;
              timeout_err     <= 1'b1;
              state           <= S_CHECK;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_CHECK: begin
            if (sel_q == LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= ~|fail_vec;
            end else begin
              state      <= S_CLEAR;
              sel_q      <= sel_q + 1'b1;
              misr_clr_q <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bist_scheduler.sv
// Directed bench for bist_scheduler with a small
// pattern-controller model driving the slave side.
module tb_bist_scheduler;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;
  logic       timeout_err;

  bist_scheduler_if #(.SEL_W(2)) bus ();

  bist_scheduler #(
    .NUM_CUT (4),
    .SEL_W   (2),
    .TO_W    (8),
    .TIMEOUT (255)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_vec    (fail_vec),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // controller model: run 80 cycles after ctrl_start, then end
  logic       mdl_run = 1'b0;
  logic       mdl_end = 1'b0;
  int         mdl_cnt = 0;
  bit         stale   = 1'b0;
  logic [3:0] fail_mask = 4'b0000;

  always @(posedge clk) begin
    if (bus.ctrl_start) begin
      mdl_run <= 1'b1;
      mdl_end <= 1'b0;
      mdl_cnt <= 1;
    end else if (mdl_cnt != 0) begin
      if (mdl_cnt == 80) begin
        mdl_run <= 1'b0;
        mdl_end <= 1'b1;
        mdl_cnt <= 0;
      end else begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end
  end

  assign bus.ctrl_running  = stale ? 1'b0 : mdl_run;
  assign bus.ctrl_bist_end = stale ? 1'b1 : mdl_end;
  assign bus.sig_match     = ~fail_mask[bus.cut_sel];

  // pulse monitor
  int          clr_cnt  = 0;
  int          go_cnt   = 0;
  int          overlap  = 0;
  int          dbl      = 0;
  logic [15:0] clr_seq  = '0;
  logic        prev_clr = 1'b0;
  logic        prev_go  = 1'b0;

  always @(posedge clk) begin
    if (bus.misr_clr) begin
      clr_cnt <= clr_cnt + 1;
      clr_seq <= {clr_seq[11:0], 2'b00, bus.cut_sel};
    end
    if (bus.ctrl_start)
      go_cnt <= go_cnt + 1;
    if (bus.misr_clr && bus.ctrl_start)
      overlap <= overlap + 1;
    if ((bus.misr_clr && prev_clr) || (bus.ctrl_start && prev_go))
      dbl <= dbl + 1;
    prev_clr <= bus.misr_clr;
    prev_go  <= bus.ctrl_start;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // returns at the CLEAR cycle of the new session
  task automatic start_session();
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input int lim);
    int i;
    i = 0;
    while (!done && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk("done_wait", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_launch(input logic [1:0] sel, input int lim);
    int i;
    i = 0;
    while (!(bus.ctrl_start && bus.cut_sel == sel) && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk("launch_wait", {31'd0, bus.ctrl_start}, 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"},
        {22'd0, bus.ctrl_start, bus.misr_clr, bus.cut_sel, busy,
         done, pass, fail_vec, timeout_err}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    // nominal pass; start stays high after the edge
    clr_cnt = 0;
    go_cnt  = 0;
    clr_seq = '0;
    start_session();
    chk("nom_clr", {31'd0, bus.misr_clr}, 32'd1);
    chk("nom_busy", {31'd0, busy}, 32'd1);
    chk("nom_sel0", {30'd0, bus.cut_sel}, 32'd0);
    @(negedge clk);
    chk("nom_launch", {30'd0, bus.ctrl_start, bus.misr_clr}, 32'd2);
    wait_done(1000);
    chk("nom_pass", {31'd0, pass}, 32'd1);
    chk("nom_fv", {28'd0, fail_vec}, 32'd0);
    chk("nom_to", {31'd0, timeout_err}, 32'd0);
    chk("nom_busy_end", {31'd0, busy}, 32'd0);
    chk("nom_seq", {16'd0, clr_seq}, 32'h0123);
    chk("nom_go_cnt", go_cnt, 4);
    repeat (10) @(negedge clk);
    chk("held_clr_cnt", clr_cnt, 4);
    chk("held_done", {30'd0, done, busy}, 32'd2);

    // single failure on CUT 2, restarted from DONE
    fail_mask = 4'b0100;
    start_session();
    chk("rst_clr", {31'd0, bus.misr_clr}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fv", {28'd0, fail_vec}, 32'd0);
    wait_done(1000);
    chk("f2_fv", {28'd0, fail_vec}, 32'h4);
    chk("f2_pass", {31'd0, pass}, 32'd0);
    chk("f2_to", {31'd0, timeout_err}, 32'd0);

    // abort during WAIT of CUT 1
    fail_mask = 4'b0001;
    start_session();
    wait_launch(2'd1, 400);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_done", {31'd0, done}, 32'd0);
    chk("ab_sel", {30'd0, bus.cut_sel}, 32'd0);
    chk("ab_fv", {28'd0, fail_vec}, 32'h1);
    repeat (5) @(negedge clk);
    chk("ab_idle", {30'd0, busy, bus.misr_clr}, 32'd0);

    // stale end flag with no running: every CUT times out
    fail_mask = 4'b0000;
    stale = 1'b1;
    start_session();
    repeat (20) @(negedge clk);
    chk("st_busy", {31'd0, busy}, 32'd1);
    chk("st_sel", {30'd0, bus.cut_sel}, 32'd0);
    chk("st_fv", {28'd0, fail_vec}, 32'd0);
    wait_done(2000);
    chk("to_fv", {28'd0, fail_vec}, 32'hf);
    chk("to_err", {31'd0, timeout_err}, 32'd1);
    chk("to_pass", {31'd0, pass}, 32'd0);
    stale = 1'b0;

    // async reset between edges in WAIT of CUT 1
    fail_mask = 4'b0001;
    start_session();
    wait_launch(2'd1, 400);
    repeat (3) @(negedge clk);
    chk("pre_rst_fv", {28'd0, fail_vec}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("async");
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("post_rst");
    fail_mask = 4'b0000;
    start_session();
    chk("rs_clr", {30'd0, bus.misr_clr, busy}, 32'd3);
    chk("rs_sel", {30'd0, bus.cut_sel}, 32'd0);
    wait_done(1000);
    chk("rs_pass", {31'd0, pass}, 32'd1);
    chk("rs_fv", {28'd0, fail_vec}, 32'd0);

    chk("no_overlap", overlap, 0);
    chk("one_cycle", dbl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
